// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the FD and DE latches.
//   - Detects load-use hazards between decode and execute. On a hazard it holds
//     PC and FD and bubbles the DE latch for LOAD_STALLS cycles.
//   - Resolves branches in execute. A taken branch redirects fetch and flushes
//     both latches in the same cycle.
//   - Generates the EX operand forwarding selects (0 = RF, 1 = MEM, 2 = WB).
//   - After reset it forces RESET_BUBBLES cycles of FD/DE flush, because the
//     pipeline latches themselves are not reset.
//
// Parameters:
//   RESET_BUBBLES : flush cycles after reset release (1..15)
//   LOAD_STALLS   : stall cycles per load-use hazard (1..7)
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   dec_rs1/rs2[_used]         decode source registers
//   ex_rf_we, ex_mem2rf,
//   ex_rf_waddr                DE-latch writeback controls (load detection)
//   ex_branch, ex_check_eq,
//   ex_eq, ex_target           branch resolution in EX
//   ex_src0, ex_src1           EX operand register indices
//   mem_rf_we/waddr            EM-stage writeback
//   wb_rf_we/waddr             MW-stage writeback
//   pc_stall, fd_stall,
//   fd_flush, de_flush         latch control outputs
//   redirect_valid/pc          fetch redirect
//   fwd_sel0, fwd_sel1         EX operand forwarding selects
//
// Optional feature (macro HAZARD_PERF_EN):
//   stall_cycles, flush_events, branch_events : 32-bit wrapping perf counters.
//
// The control outputs are combinational because a taken branch must redirect
// and flush in the same cycle it resolves. While rst_n is low they are forced
// to the reset values so that they are defined before the first clock edge.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int RESET_BUBBLES = 2,
    parameter int LOAD_STALLS   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_rs1_used,
    input  logic        dec_rs2_used,
    input  logic        ex_rf_we,
    input  logic        ex_mem2rf,
    input  logic [31:0] ex_rf_waddr,
    input  logic        ex_branch,
    input  logic        ex_check_eq,
    input  logic        ex_eq,
    input  logic [31:0] ex_target,
    input  logic [4:0]  ex_src0,
    input  logic [4:0]  ex_src1,
    input  logic        mem_rf_we,
    input  logic [4:0]  mem_rf_waddr,
    input  logic        wb_rf_we,
    input  logic [4:0]  wb_rf_waddr,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] branch_events,
`endif
    output logic        pc_stall,
    output logic        fd_stall,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  fwd_sel0,
    output logic [1:0]  fwd_sel1
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] INIT_RELOAD  = 4'(RESET_BUBBLES - 1);
    // The first stall cycle is spent in RUN, so STALL counts the remainder.
    localparam logic [3:0] STALL_RELOAD = (LOAD_STALLS > 1) ? 4'(LOAD_STALLS - 2) : 4'd0;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_next_s;
    logic       taken_s;
    logic       lu_s;
    logic [4:0] ld_dst_s;

    // Forwarding select for one EX operand; MEM is younger so it wins over WB.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] src,
        input logic       m_we,
        input logic [4:0] m_addr,
        input logic       w_we,
        input logic [4:0] w_addr
    );
        logic [1:0] sel;
        if (src == 5'd0) begin
            sel = 2'd0;
        end else if (m_we && (m_addr == src)) begin
            sel = 2'd1;
        end else if (w_we && (w_addr == src)) begin
            sel = 2'd2;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    assign ld_dst_s = ex_rf_waddr[4:0];
    assign taken_s  = ex_branch & (ex_check_eq ? ex_eq : ~ex_eq);
    assign lu_s     = ex_mem2rf & ex_rf_we & (ld_dst_s != 5'd0) &
                      ((dec_rs1_used & (dec_rs1 == ld_dst_s)) |
                       (dec_rs2_used & (dec_rs2 == ld_dst_s)));

    // State and bubble/stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= INIT;
            cnt_r   <= INIT_RELOAD;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state, latch control, redirect and forwarding outputs.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        pc_stall       = 1'b0;
        fd_stall       = 1'b0;
        fd_flush       = 1'b0;
        de_flush       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fwd_sel0       = 2'd0;
        fwd_sel1       = 2'd0;

        if (!rst_n) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else begin
            fwd_sel0 = fwd_select(ex_src0, mem_rf_we, mem_rf_waddr, wb_rf_we, wb_rf_waddr);
            fwd_sel1 = fwd_select(ex_src1, mem_rf_we, mem_rf_waddr, wb_rf_we, wb_rf_waddr);

            case (state_r)
                INIT: begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    if (cnt_r == 4'd0) begin
                        state_next_s = RUN;
                    end else begin
                        cnt_next_s = cnt_r - 4'd1;
                    end
                end
                RUN: begin
                    if (taken_s) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        fd_flush       = 1'b1;
                        de_flush       = 1'b1;
                        state_next_s   = FLUSH;
                    end else if (lu_s) begin
                        pc_stall = 1'b1;
                        fd_stall = 1'b1;
                        de_flush = 1'b1;
                        if (LOAD_STALLS > 1) begin
                            state_next_s = STALL;
                            cnt_next_s   = STALL_RELOAD;
                        end else begin
                            state_next_s = RUN;
                        end
                    end else begin
                        state_next_s = RUN;
                    end
                end
                STALL: begin
                    // A taken branch squashes the stalled load consumer anyway.
                    if (taken_s) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        fd_flush       = 1'b1;
                        de_flush       = 1'b1;
                        state_next_s   = FLUSH;
                    end else begin
                        pc_stall = 1'b1;
                        fd_stall = 1'b1;
                        de_flush = 1'b1;
                        if (cnt_r == 4'd0) begin
                            state_next_s = RUN;
                        end else begin
                            cnt_next_s = cnt_r - 4'd1;
                        end
                    end
                end
                FLUSH: begin
                    // Decode holds a squashed bubble here, so no load-use check.
                    if (taken_s) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        fd_flush       = 1'b1;
                        de_flush       = 1'b1;
                        state_next_s   = FLUSH;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                default: begin
                    fd_flush     = 1'b1;
                    de_flush     = 1'b1;
                    state_next_s = INIT;
                    cnt_next_s   = INIT_RELOAD;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_r;
    logic [31:0] flush_events_r;
    logic [31:0] branch_events_r;

    // Performance counters; all wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_r  <= 32'd0;
            flush_events_r  <= 32'd0;
            branch_events_r <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cycles_r <= stall_cycles_r + 32'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (state_next_s == FLUSH) begin
                flush_events_r <= flush_events_r + 32'd1;
            end else begin
                flush_events_r <= flush_events_r;
            end
            if (ex_branch && (state_r != INIT)) begin
                branch_events_r <= branch_events_r + 32'd1;
            end else begin
                branch_events_r <= branch_events_r;
            end
        end
    end

    assign stall_cycles  = stall_cycles_r;
    assign flush_events  = flush_events_r;
    assign branch_events = branch_events_r;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share all inputs:
//   u_dut  : RESET_BUBBLES=2, LOAD_STALLS=1
//   u_dut3 : RESET_BUBBLES=2, LOAD_STALLS=3
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  dec_rs1, dec_rs2;
    logic        dec_rs1_used, dec_rs2_used;
    logic        ex_rf_we, ex_mem2rf;
    logic [31:0] ex_rf_waddr;
    logic        ex_branch, ex_check_eq, ex_eq;
    logic [31:0] ex_target;
    logic [4:0]  ex_src0, ex_src1;
    logic        mem_rf_we, wb_rf_we;
    logic [4:0]  mem_rf_waddr, wb_rf_waddr;

    logic        pc_stall, fd_stall, fd_flush, de_flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  fwd_sel0, fwd_sel1;
    logic        pc_stall3, fd_stall3, fd_flush3, de_flush3, redirect_valid3;
    logic [31:0] redirect_pc3;
    logic [1:0]  fwd_sel0_3, fwd_sel1_3;
`ifdef HAZARD_PERF_EN
    logic [31:0] sc1, fe1, be1, sc3, fe3, be3;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.RESET_BUBBLES(2), .LOAD_STALLS(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .ex_rf_we(ex_rf_we), .ex_mem2rf(ex_mem2rf), .ex_rf_waddr(ex_rf_waddr),
        .ex_branch(ex_branch), .ex_check_eq(ex_check_eq), .ex_eq(ex_eq),
        .ex_target(ex_target), .ex_src0(ex_src0), .ex_src1(ex_src1),
        .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
        .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
`ifdef HAZARD_PERF_EN
        .stall_cycles(sc1), .flush_events(fe1), .branch_events(be1),
`endif
        .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
        .de_flush(de_flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1)
    );

    hazard_ctrl #(.RESET_BUBBLES(2), .LOAD_STALLS(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .ex_rf_we(ex_rf_we), .ex_mem2rf(ex_mem2rf), .ex_rf_waddr(ex_rf_waddr),
        .ex_branch(ex_branch), .ex_check_eq(ex_check_eq), .ex_eq(ex_eq),
        .ex_target(ex_target), .ex_src0(ex_src0), .ex_src1(ex_src1),
        .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
        .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr),
`ifdef HAZARD_PERF_EN
        .stall_cycles(sc3), .flush_events(fe3), .branch_events(be3),
`endif
        .pc_stall(pc_stall3), .fd_stall(fd_stall3), .fd_flush(fd_flush3),
        .de_flush(de_flush3), .redirect_valid(redirect_valid3),
        .redirect_pc(redirect_pc3), .fwd_sel0(fwd_sel0_3), .fwd_sel1(fwd_sel1_3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {pc_stall, fd_stall, fd_flush, de_flush, redirect_valid} of one instance.
    function automatic logic [31:0] ctl1();
        return {27'd0, pc_stall, fd_stall, fd_flush, de_flush, redirect_valid};
    endfunction
    function automatic logic [31:0] ctl3();
        return {27'd0, pc_stall3, fd_stall3, fd_flush3, de_flush3, redirect_valid3};
    endfunction

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
        ex_rf_we = 1'b0; ex_mem2rf = 1'b0; ex_rf_waddr = 32'd0;
        ex_branch = 1'b0; ex_check_eq = 1'b0; ex_eq = 1'b0; ex_target = 32'd0;
        ex_src0 = 5'd0; ex_src1 = 5'd0;
        mem_rf_we = 1'b0; mem_rf_waddr = 5'd0; wb_rf_we = 1'b0; wb_rf_waddr = 5'd0;
    endtask

    task automatic set_load_use(input logic [31:0] waddr);
        ex_mem2rf = 1'b1; ex_rf_we = 1'b1; ex_rf_waddr = waddr;
        dec_rs2 = waddr[4:0]; dec_rs2_used = 1'b1;
    endtask

    // Bit order of ctl: {pc_stall, fd_stall, fd_flush, de_flush, redirect_valid}
    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        next_cycle(); #1;
        check("reset_ctl", ctl1(), 32'b00110);
        check("reset_pc",  redirect_pc, 32'd0);

        // Release reset: exactly two flush cycles, then RUN.
        next_cycle(); rst_n = 1'b1; #1;
        check("init_c1", ctl1(), 32'b00110);
        next_cycle(); #1;
        check("init_c2", ctl1(), 32'b00110);
        next_cycle(); #1;
        check("run_idle", ctl1(), 32'b00000);
        check("run_idle3", ctl3(), 32'b00000);

        // Load-use on rs2 = x5.
        next_cycle(); set_load_use(32'd5); #1;
        check("lu_stall",  ctl1(), 32'b11010);
        check("lu_stall3", ctl3(), 32'b11010);
        next_cycle(); clear_inputs(); #1;
        check("lu_done",  ctl1(), 32'b00000);
        check("lu3_c2",   ctl3(), 32'b11010);
        next_cycle(); #1;
        check("lu3_c3",   ctl3(), 32'b11010);
        next_cycle(); #1;
        check("lu3_done", ctl3(), 32'b00000);

        // Load to x0 is not a hazard.
        next_cycle(); set_load_use(32'd0); #1;
        check("lu_x0", ctl1(), 32'b00000);
        // Upper waddr bits are ignored: 0x25 compares as x5.
        next_cycle(); clear_inputs(); set_load_use(32'h25); dec_rs2 = 5'd5; #1;
        check("lu_hibits", ctl1(), 32'b11010);
        next_cycle(); clear_inputs(); #1;
        repeat (2) next_cycle();

        // Not-taken branch (check_eq=1, eq=0).
        next_cycle(); ex_branch = 1'b1; ex_check_eq = 1'b1; ex_eq = 1'b0; ex_target = 32'h80; #1;
        check("br_nt", ctl1(), 32'b00000);
        // Taken branch on equal.
        next_cycle(); ex_eq = 1'b1; ex_target = 32'h40; #1;
        check("br_ctl", ctl1(), 32'b00111);
        check("br_pc",  redirect_pc, 32'h40);
        // FLUSH cycle: load-use suppressed.
        next_cycle(); clear_inputs(); set_load_use(32'd5); #1;
        check("flush_nolu",  ctl1(), 32'b00000);
        check("flush_nolu3", ctl3(), 32'b00000);
        // Back in RUN the same inputs stall (LOAD_STALLS=1 instance only kept).
        next_cycle(); #1;
        check("after_flush_lu", ctl1(), 32'b11010);
        next_cycle(); clear_inputs();
        repeat (3) next_cycle();

        // Taken branch (check_eq=0, eq=0) in the 2nd stall cycle of u_dut3.
        next_cycle(); set_load_use(32'd9); #1;
        check("st3_c1", ctl3(), 32'b11010);
        next_cycle(); clear_inputs();
        ex_branch = 1'b1; ex_check_eq = 1'b0; ex_eq = 1'b0; ex_target = 32'h1234; #1;
        check("st3_br_ctl", ctl3(), 32'b00111);
        check("st3_br_pc",  redirect_pc3, 32'h1234);
        next_cycle(); clear_inputs(); set_load_use(32'd9); #1;
        check("st3_flush", ctl3(), 32'b00000);
        next_cycle(); clear_inputs();
        repeat (3) next_cycle();

        // Forwarding.
        next_cycle(); mem_rf_we = 1'b1; mem_rf_waddr = 5'd7; wb_rf_we = 1'b1; wb_rf_waddr = 5'd7;
        ex_src0 = 5'd7; ex_src1 = 5'd0; #1;
        check("fwd_mem_wins", {30'd0, fwd_sel0}, 32'd1);
        check("fwd_src1_x0",  {30'd0, fwd_sel1}, 32'd0);
        next_cycle(); mem_rf_we = 1'b0; #1;
        check("fwd_wb", {30'd0, fwd_sel0}, 32'd2);
        next_cycle(); mem_rf_we = 1'b1; mem_rf_waddr = 5'd0; wb_rf_waddr = 5'd0; ex_src0 = 5'd0; #1;
        check("fwd_x0_both", {30'd0, fwd_sel1}, 32'd0);
        next_cycle(); mem_rf_waddr = 5'd3; wb_rf_waddr = 5'd4; ex_src0 = 5'd4; ex_src1 = 5'd3; #1;
        check("fwd_split0", {30'd0, fwd_sel0}, 32'd2);
        check("fwd_split1", {30'd0, fwd_sel1}, 32'd1);
        next_cycle(); clear_inputs();

        // Reset in the middle of a u_dut3 stall.
        next_cycle(); set_load_use(32'd6); #1;
        check("rst_st_c1", ctl3(), 32'b11010);
        next_cycle(); clear_inputs(); #1;
        check("rst_st_c2", ctl3(), 32'b11010);
        next_cycle(); rst_n = 1'b0; #1;
        check("rst_mid_stall", ctl3(), 32'b00110);
        next_cycle(); rst_n = 1'b1; #1;
        check("rst_init_c1", ctl3(), 32'b00110);
        next_cycle(); #1;
        check("rst_init_c2", ctl3(), 32'b00110);
        next_cycle(); #1;
        check("rst_run", ctl3(), 32'b00000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
